// File: rtl/cplm_pkg.sv
// Shared definitions for the complement/load/clear register sequencer:
// op codes, FSM states and the register next-value rule.
package cplm_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CPL  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Value the register holds after one cycle in mode op; callers truncate to their width.
  function automatic logic [31:0] shadow_next(input logic [1:0] op,
                                              input logic [31:0] data,
                                              input logic [31:0] cur);
    case (op)
      OP_CPL:  return ~cur;
      OP_LOAD: return data;
      OP_CLR:  return '0;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/cplm_cmd_fifo.sv
// Synchronous command FIFO; full/empty derive only from registered pointers.
module cplm_cmd_fifo #(
  parameter int DW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cplm_reg_sequencer.sv
// Command-side initiator for the 4-bit complement/load/clear register: issues one
// mode cycle per command, checks the readback against a shadow and returns it.
module cplm_reg_sequencer
  import cplm_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] parallel_data,
  input  logic [WIDTH-1:0] reg_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a command transfers on a clk edge with cmd_valid && cmd_ready, a
  // response on a clk edge with rsp_valid && rsp_ready; rsp_* hold while stalled.

  state_e           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shadow;
  logic [1:0]       sel_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH+1:0] head;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_data;

  assign head_op   = head[WIDTH+1:WIDTH];
  assign head_data = (head_op == OP_LOAD) ? head[WIDTH-1:0] : '0;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state = state;
  assign S1        = sel_q[1];
  assign S0        = sel_q[0];

  cplm_cmd_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({cmd_op, cmd_data}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= OP_HOLD;
      data_q        <= '0;
      shadow        <= '0;
      sel_q         <= 2'b00;
      parallel_data <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      // Register mode lines idle unless this edge starts an ISSUE cycle.
      sel_q         <= 2'b00;
      parallel_data <= '0;
      if (err_clr) err_sticky <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_q          <= head_op;
            data_q        <= head_data;
            sel_q         <= head_op;
            parallel_data <= head_data;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          shadow <= WIDTH'(shadow_next(op_q, 32'(data_q), 32'(shadow)));
          state  <= ST_CHECK;
        end
        ST_CHECK: begin
          rsp_data  <= reg_in;
          rsp_err   <= (reg_in != shadow);
          rsp_valid <= 1'b1;
          if (reg_in != shadow) begin
            shadow     <= reg_in;
            err_sticky <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cplm_reg_sequencer.sv
// Directed bench for cplm_reg_sequencer with a behavioural register, a response
// scoreboard built from the op rules, and literal pins on key responses.
module tb_cplm_reg_sequencer;
  import cplm_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         S1;
  logic         S0;
  logic [W-1:0] parallel_data;
  logic [W-1:0] reg_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         err_sticky;
  logic         err_clr;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q [$];
  logic [W:0] got_q [$];
  int         nz_cnt = 0;

  logic [W-1:0] reg_q;
  logic         fault_arm;
  logic [W-1:0] fault_val;
  logic [W-1:0] m_reg;
  logic [W-1:0] m_shadow;

  cplm_reg_sequencer #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .S1            (S1),
    .S0            (S0),
    .parallel_data (parallel_data),
    .reg_in        (reg_in),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .err_sticky    (err_sticky),
    .err_clr       (err_clr),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register; fault_arm corrupts the value stored by a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else if ({S1, S0} == OP_LOAD && fault_arm) reg_q <= fault_val;
    else reg_q <= W'(shadow_next({S1, S0}, 32'(parallel_data), 32'(reg_q)));
  end
  assign reg_in = reg_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] apply_op(input logic [1:0] op, input logic [W-1:0] d,
                                            input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    if (op == 2'b01) r = ~v;
    if (op == 2'b10) r = d;
    if (op == 2'b11) r = '0;
    return r;
  endfunction

  // Monitor, model and compare: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] nv;
    logic [W-1:0] sv;
    logic         e;
    if (!rst_n) begin
      exp_q.delete();
      m_reg    = '0;
      m_shadow = '0;
    end else begin
      if ({S1, S0} != 2'b00) nz_cnt++;
      if ({S1, S0} != OP_LOAD) check("pd_idle", 32'(parallel_data), 32'h0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          check("rsp", 32'({rsp_err, rsp_data}), 32'(exp_q[0]));
          if (rsp_ready) begin
            got_q.push_back({rsp_err, rsp_data});
            void'(exp_q.pop_front());
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        nv = apply_op(cmd_op, cmd_data, m_reg);
        if (cmd_op == 2'b10 && fault_arm) nv = fault_val;
        sv = apply_op(cmd_op, cmd_data, m_shadow);
        e  = (nv != sv);
        m_shadow = nv;
        m_reg    = nv;
        exp_q.push_back({e, nv});
      end
    end
  end

  // Driver tasks: called just after a posedge.
  task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'h1);
    if (cmd_ready) @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 500);
    check("drain", 32'({busy, exp_q.size() != 0}), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic pin_got(input string name, input int idx, input logic [W:0] exp);
    if (idx < got_q.size()) check(name, 32'(got_q[idx]), 32'(exp));
    else check({name, "_missing"}, idx, got_q.size());
  endtask

  initial begin
    int base;
    int nz_base;
    int lat;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    err_clr   = 1'b0;
    fault_arm = 1'b0;
    fault_val = '0;
    rst_n     = 1'b0;

    // 1: reset values
    #12;
    check("rst_sel", 32'({S1, S0}), 32'h0);
    check("rst_pd", 32'(parallel_data), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_err_sticky", 32'(err_sticky), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: basic sequence and latency
    base    = got_q.size();
    nz_base = nz_cnt;
    push_cmd(OP_LOAD, 4'hA);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    @(posedge clk);
    #1;
    push_cmd(OP_CPL, 4'h0);
    push_cmd(OP_CPL, 4'h7);
    push_cmd(OP_CLR, 4'h0);
    push_cmd(OP_HOLD, 4'h0);
    wait_idle();
    pin_got("t2_r0", base + 0, 5'h0A);
    pin_got("t2_r1", base + 1, 5'h05);
    pin_got("t2_r2", base + 2, 5'h0A);
    pin_got("t2_r3", base + 3, 5'h00);
    pin_got("t2_r4", base + 4, 5'h00);
    check("t2_sel_cycles", nz_cnt - nz_base, 4);

    // 3: backpressure, FIFO fills behind a stalled response
    base = got_q.size();
    rsp_ready = 1'b0;
    push_cmd(OP_LOAD, 4'h3);
    push_cmd(OP_CPL, 4'h0);
    push_cmd(OP_LOAD, 4'h9);
    push_cmd(OP_HOLD, 4'h0);
    push_cmd(OP_CPL, 4'h0);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    cmd_data  = 4'h0;
    repeat (4) begin
      @(negedge clk);
      check("t3_cmd_ready_low", 32'(cmd_ready), 32'h0);
      check("t3_rsp_stalled", 32'({rsp_valid, rsp_data}), 32'h13);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    push_cmd(OP_CLR, 4'h0);
    wait_idle();
    check("t3_count", got_q.size() - base, 6);
    pin_got("t3_r0", base + 0, 5'h03);
    pin_got("t3_r1", base + 1, 5'h0C);
    pin_got("t3_r4", base + 4, 5'h06);
    pin_got("t3_r5", base + 5, 5'h00);

    // 4: fault injection and shadow resync
    base = got_q.size();
    fault_arm = 1'b1;
    fault_val = 4'h3;
    push_cmd(OP_LOAD, 4'hC);
    wait_idle();
    fault_arm = 1'b0;
    check("t4_sticky", 32'(err_sticky), 32'h1);
    push_cmd(OP_CPL, 4'h0);
    wait_idle();
    pin_got("t4_fault", base + 0, 5'h13);
    pin_got("t4_resync", base + 1, 5'h0C);

    // 5: err_clr against a coincident mismatch
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("t5_clr_alone", 32'(err_sticky), 32'h0);
    base = got_q.size();
    fault_arm = 1'b1;
    fault_val = 4'h9;
    push_cmd(OP_LOAD, 4'h5);
    @(posedge clk);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("t5_set_wins", 32'(err_sticky), 32'h1);
    wait_idle();
    fault_arm = 1'b0;
    pin_got("t5_rsp", base, 5'h19);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("t5_clr_later", 32'(err_sticky), 32'h0);

    // 6: reset during ISSUE abandons the command
    base = got_q.size();
    push_cmd(OP_LOAD, 4'hF);
    @(posedge clk);
    #2;
    check("t6_issue_state", 32'(dbg_state), 32'(ST_ISSUE));
    check("t6_issue_drive", 32'({S1, S0, parallel_data}), 32'h2F);
    rst_n = 1'b0;
    #1;
    check("t6_rst_drive", 32'({S1, S0, parallel_data}), 32'h0);
    check("t6_rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'h0);
    check("t6_rst_flags", 32'({err_sticky, busy, cmd_ready}), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t6_no_rsp", 32'({rsp_valid, busy}), 32'h0);
    end
    @(posedge clk);
    #1;
    push_cmd(OP_HOLD, 4'h0);
    wait_idle();
    check("t6_count", got_q.size() - base, 1);
    pin_got("t6_hold", base, 5'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
